// File: rtl/uart_bus_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : uart_bus_bridge
//  Description : Arbitrates NCH bus requesters onto a byte-serial link; sends a
//                request packet, then collects read data or a write ack.
//  Revision    : 1.0
// ============================================================================
module uart_bus_bridge #(
  parameter int NCH     = 2,
  parameter int TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    req_ce,
  input  logic [NCH-1:0]    req_we,
  input  logic [NCH*32-1:0] req_addr,
  input  logic [NCH*32-1:0] req_wdata,
  input  logic [NCH*4-1:0]  req_byte,
  output logic [NCH-1:0]    req_stall,
  output logic [NCH-1:0]    req_done,
  output logic [31:0]       req_rdata,
  output logic              req_err,
  output logic              send_ce,
  output logic [7:0]        send_data,
  input  logic              send_busy,
  input  logic              recv_valid,
  input  logic [7:0]        recv_data,
  input  logic              recv_fault
);

  localparam int c_ch_w  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int c_gap_w = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GRANT  = 3'd1,
    TX     = 3'd2,
    TXWAIT = 3'd3,
    RX     = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t              r_state;
  logic [c_ch_w-1:0]   r_last;
  logic [c_ch_w-1:0]   r_grant;
  logic                r_we;
  logic [31:0]         r_addr;
  logic [31:0]         r_wdata;
  logic [3:0]          r_mask;
  logic [3:0]          r_idx;
  logic                r_hold;
  logic [1:0]          r_rx_cnt;
  logic [23:0]         r_rx_data;
  logic [c_gap_w-1:0]  r_gap;

  logic [c_ch_w-1:0]   w_sel;
  logic [c_ch_w-1:0]   w_cand;
  logic                w_any;
  logic                w_g_we;
  logic [31:0]         w_g_addr;
  logic [31:0]         w_g_wdata;
  logic [3:0]          w_g_mask;
  logic [7:0]          w_tx_byte;
  logic [3:0]          w_last_idx;
  logic [NCH-1:0]      w_grant_oh;

  assign req_stall  = req_ce & ~req_done;
  assign w_last_idx = r_we ? 4'd8 : 4'd4;
  assign w_grant_oh = NCH'(1) << r_grant;

  // Round-robin: scan from the channel after r_last; the nearest requester wins.
  always_comb begin
    w_sel  = '0;
    w_cand = '0;
    w_any  = 1'b0;
    for (int k = NCH; k >= 1; k--) begin
      w_cand = c_ch_w'((int'(r_last) + k) % NCH);
      if (req_ce[w_cand]) begin
        w_sel = w_cand;
        w_any = 1'b1;
      end
    end
  end

  always_comb begin
    w_g_we    = 1'b0;
    w_g_addr  = '0;
    w_g_wdata = '0;
    w_g_mask  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (r_grant == c_ch_w'(i)) begin
        w_g_we    = req_we[i];
        w_g_addr  = req_addr[32*i +: 32];
        w_g_wdata = req_wdata[32*i +: 32];
        w_g_mask  = req_byte[4*i +: 4];
      end
    end
  end

  always_comb begin
    case (r_idx)
      4'd0:    w_tx_byte = {r_we, 3'b000, r_mask};
      4'd1:    w_tx_byte = r_addr[7:0];
      4'd2:    w_tx_byte = r_addr[15:8];
      4'd3:    w_tx_byte = r_addr[23:16];
      4'd4:    w_tx_byte = r_addr[31:24];
      4'd5:    w_tx_byte = r_wdata[7:0];
      4'd6:    w_tx_byte = r_wdata[15:8];
      4'd7:    w_tx_byte = r_wdata[23:16];
      4'd8:    w_tx_byte = r_wdata[31:24];
      default: w_tx_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_last    <= c_ch_w'(NCH - 1);
      r_grant   <= '0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_mask    <= '0;
      r_idx     <= '0;
      r_hold    <= 1'b0;
      r_rx_cnt  <= '0;
      r_rx_data <= '0;
      r_gap     <= '0;
      send_ce   <= 1'b0;
      send_data <= 8'h00;
      req_done  <= '0;
      req_rdata <= '0;
      req_err   <= 1'b0;
    end else begin
      send_ce  <= 1'b0;
      req_done <= '0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant <= w_sel;
            r_state <= GRANT;
          end
        end
        GRANT: begin
          r_we    <= w_g_we;
          r_addr  <= w_g_addr;
          r_wdata <= w_g_wdata;
          r_mask  <= w_g_mask;
          r_idx   <= '0;
          r_state <= TX;
        end
        TX: begin
          if (!send_busy) begin
            send_ce   <= 1'b1;
            send_data <= w_tx_byte;
            r_hold    <= 1'b1;
            r_state   <= TXWAIT;
          end
        end
        TXWAIT: begin
          // The transmitter sees send_ce only at the end of the first cycle here,
          // so its busy flag is not meaningful until the cycle after.
          if (r_hold) begin
            r_hold <= 1'b0;
          end else if (!send_busy) begin
            if (r_idx == w_last_idx) begin
              r_rx_cnt <= '0;
              r_gap    <= '0;
              r_state  <= RX;
            end else begin
              r_idx   <= r_idx + 4'd1;
              r_state <= TX;
            end
          end
        end
        RX: begin
          if (recv_fault) begin
            req_err   <= 1'b1;
            req_rdata <= '0;
            req_done  <= w_grant_oh;
            r_state   <= DONE;
          end else if (recv_valid) begin
            r_gap     <= '0;
            r_rx_cnt  <= r_rx_cnt + 2'd1;
            r_rx_data <= {recv_data, r_rx_data[23:8]};
            if (r_we) begin
              req_err   <= (recv_data != 8'h00);
              req_rdata <= '0;
              req_done  <= w_grant_oh;
              r_state   <= DONE;
            end else if (r_rx_cnt == 2'd3) begin
              req_err   <= 1'b0;
              req_rdata <= {recv_data, r_rx_data};
              req_done  <= w_grant_oh;
              r_state   <= DONE;
            end
          end else if (r_gap == c_gap_w'(TIMEOUT - 1)) begin
            req_err   <= 1'b1;
            req_rdata <= '0;
            req_done  <= w_grant_oh;
            r_state   <= DONE;
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
        DONE: begin
          r_last  <= r_grant;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
